cart_mem_bridge: RTL

- Downstream of the MegaRAM/SCC mapper: turns the mapper's 23-bit `mem_addr`, `cart_ena` and `ram_ena`, plus the raw MSX strobes, into single-byte transactions on the on-board PSRAM/SDRAM controller request port.
- Returns read data to the cartridge bus with a bus-drive request.
- Optionally stalls the Z80 through WAIT while an access is outstanding.

---
 rtl/cart_mem_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cart_mem_bridge.sv
// Bridges mapped MSX cartridge accesses onto a single-byte memory request/ack port.
// Optional macro CART_MEM_WAIT_EN drives MSX WAIT while a memory transaction is outstanding.
module cart_mem_bridge #(
  parameter int ADDR_W      = 23,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 63
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              cart_ena,
  input  logic              ram_ena,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        cdin,
  output logic [7:0]        cdout,
  output logic              busreq,
  output logic              wait_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, ACKWAIT, HOLD} state_t;

  state_t              state_q;
  logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, ce_sync_q;
  logic                rd_prev_q, wr_prev_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_read_q;
  logic                rel_q;
  logic [7:0]          cdout_q;
  logic                busreq_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_a_q;
  logic [7:0]          mem_wdata_q;
  logic                err_q;

  logic rd_s, wr_s, ce_s;
  logic rd_start, wr_start, mem_start;
  logic own_s, tmo, done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      ce_sync_q <= '0;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_n};
      ce_sync_q <= {ce_sync_q[SYNC_STAGES-2:0], cart_ena};
      rd_prev_q <= rd_s;
      wr_prev_q <= wr_s;
    end
  end

  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign ce_s = ce_sync_q[SYNC_STAGES-1];

  // A strobe counts only if the other one is still high; both low is not an access.
  assign rd_start  = rd_prev_q & ~rd_s & wr_s & ce_s;
  assign wr_start  = wr_prev_q & ~wr_s & rd_s & ce_s;
  assign mem_start = (state_q == IDLE) & (rd_start | (wr_start & ram_ena));

  assign own_s = is_read_q ? rd_s : wr_s;
  assign tmo   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done  = (state_q == ACKWAIT) & (mem_ack | tmo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_read_q   <= 1'b0;
      rel_q       <= 1'b0;
      cdout_q     <= 8'hFF;
      busreq_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_wdata_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busreq_q <= 1'b0;
          rel_q    <= 1'b0;
          if (rd_start) begin
            mem_a_q   <= mem_addr;
            mem_we_q  <= 1'b0;
            is_read_q <= 1'b1;
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= REQ;
          end else if (wr_start && ram_ena) begin
            mem_a_q     <= mem_addr;
            mem_wdata_q <= cdin;
            mem_we_q    <= 1'b1;
            is_read_q   <= 1'b0;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= REQ;
          end else if (wr_start) begin
            // Bank-switch write: the mapper owns it, we only track the strobe.
            is_read_q <= 1'b0;
            state_q   <= HOLD;
          end
        end
        REQ: begin
          cnt_q   <= cnt_q + 1'b1;
          rel_q   <= rel_q | own_s;
          state_q <= ACKWAIT;
        end
        ACKWAIT: begin
          if (mem_ack || tmo) begin
            mem_req_q <= 1'b0;
            if (mem_ack) begin
              if (is_read_q) cdout_q <= mem_rdata;
            end else begin
              cdout_q <= 8'hFF;
              err_q   <= 1'b1;
            end
            state_q <= (rel_q | own_s) ? IDLE : HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            rel_q <= rel_q | own_s;
          end
        end
        HOLD: begin
          if (own_s) begin
            busreq_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            busreq_q <= is_read_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CART_MEM_WAIT_EN
  logic wait_n_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_n_q <= 1'b1;
    end else if (mem_start) begin
      wait_n_q <= 1'b0;
    end else if (done) begin
      wait_n_q <= 1'b1;
    end
  end

  assign wait_n = wait_n_q;
`else
  logic unused_ok;
  assign unused_ok = mem_start ^ done;
  assign wait_n    = 1'b1;
`endif

  assign cdout     = cdout_q;
  assign busreq    = busreq_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_a     = mem_a_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
